// File: rtl/display_slot_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_slot_scheduler_pkg
//  Purpose  : Shared mux-select codes, FSM state codes and grant helpers
//  Revision : 1.0  initial release
// ============================================================================
package display_slot_scheduler_pkg;

    localparam logic [1:0] SEL_D0   = 2'b00;
    localparam logic [1:0] SEL_D1   = 2'b01;
    localparam logic [1:0] SEL_D2   = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    function automatic logic [1:0] grant_to_sel(input logic [2:0] g);
        case (g)
            3'b001:  grant_to_sel = SEL_D0;
            3'b010:  grant_to_sel = SEL_D1;
            3'b100:  grant_to_sel = SEL_D2;
            default: grant_to_sel = SEL_NONE;
        endcase
    endfunction

    // Only meaningful for a one-hot grant; idle maps to 2 so D0 is searched first.
    function automatic logic [1:0] grant_to_idx(input logic [2:0] g);
        case (g)
            3'b001:  grant_to_idx = 2'd0;
            3'b010:  grant_to_idx = 2'd1;
            default: grant_to_idx = 2'd2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_slot_scheduler_rr_pick3.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick3
//  Purpose  : Combinational 3-way round-robin pick, order ptr+1, ptr+2, ptr
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] pick,
    output logic       valid
);

    always_comb begin
        pick = 3'b000;
        case (ptr)
            2'd0: begin
                if      (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            2'd1: begin
                if      (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if      (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
    end

    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/display_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : display_slot_scheduler
//  Purpose  : Round-robin time-sharing of one 7-segment digit between 3 sources
//  Revision : 1.0  initial release
// ============================================================================
module display_slot_scheduler
    import display_slot_scheduler_pkg::*;
#(
    parameter int DWELL = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       hold,
    output logic [1:0] sel,
    output logic [2:0] grant,
    output logic       slot_end,
    output logic       busy
);

    localparam int            CW     = $clog2(DWELL + 1);
    localparam logic [CW-1:0] c_last = CW'(DWELL - 1);

    logic [0:0]    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_ptr, w_ptr_nxt;
    logic [2:0]    r_grant, w_grant_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic          r_slot_end, w_slot_end_nxt;
    logic          r_busy, w_busy_nxt;

    logic [1:0]    w_owner;
    logic          w_owner_act;
    logic [1:0]    w_search_ptr;
    logic [2:0]    w_pick;
    logic          w_pick_valid;

    assign w_owner      = grant_to_idx(r_grant);
    assign w_owner_act  = |(req & r_grant);
    // In SHOW the search always starts after the current owner.
    assign w_search_ptr = (r_state == ST_SHOW) ? w_owner : r_ptr;

    rr_pick3 u_pick (
        .req   (req),
        .ptr   (w_search_ptr),
        .pick  (w_pick),
        .valid (w_pick_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ptr      <= 2'd2;
            r_grant    <= 3'b000;
            r_sel      <= SEL_NONE;
            r_slot_end <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_sel      <= w_sel_nxt;
            r_slot_end <= w_slot_end_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_slot_end_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_pick_valid) begin
                    w_state_nxt = ST_SHOW;
                    w_grant_nxt = w_pick;
                end
            end
            default: begin
                if (!w_owner_act) begin
                    // Abort beats both hold and the dwell end.
                    w_ptr_nxt   = w_owner;
                    w_cnt_nxt   = '0;
                    w_grant_nxt = w_pick;
                    w_state_nxt = w_pick_valid ? ST_SHOW : ST_IDLE;
                end else if (hold) begin
                    w_cnt_nxt = r_cnt;
                end else if (r_cnt != c_last) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end else begin
                    w_slot_end_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                    w_ptr_nxt      = w_owner;
                    w_grant_nxt    = w_pick;
                end
            end
        endcase
    end

    always_comb begin
        w_sel_nxt  = grant_to_sel(w_grant_nxt);
        w_busy_nxt = (w_state_nxt == ST_SHOW);
    end

    assign sel      = r_sel;
    assign grant    = r_grant;
    assign slot_end = r_slot_end;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_display_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_slot_scheduler
//  Purpose  : Scoreboard bench for display_slot_scheduler (DWELL=4 and DWELL=1)
//  Revision : 1.0  initial release
// ============================================================================
module tb_display_slot_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req   = 3'b000;
    logic       hold  = 1'b0;

    logic [1:0] sel4, sel1;
    logic [2:0] grant4, grant1;
    logic       se4, se1, busy4, busy1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        bit         which;
        logic [2:0] grant;
        logic       se;
        logic       busy;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;

    display_slot_scheduler #(.DWELL(4)) dut4 (
        .clock(clock), .reset(reset), .req(req), .hold(hold),
        .sel(sel4), .grant(grant4), .slot_end(se4), .busy(busy4)
    );

    display_slot_scheduler #(.DWELL(1)) dut1 (
        .clock(clock), .reset(reset), .req(req), .hold(hold),
        .sel(sel1), .grant(grant1), .slot_end(se1), .busy(busy1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [1:0] exp_sel(input logic [2:0] g);
        case (g)
            3'b001:  exp_sel = 2'b00;
            3'b010:  exp_sel = 2'b01;
            3'b100:  exp_sel = 2'b10;
            default: exp_sel = 2'b11;
        endcase
    endfunction

    // Monitor: compare every expectation that has come due.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            logic [1:0] s;
            logic [2:0] g;
            logic       se, b;
            e = q.pop_front();
            s  = e.which ? sel1   : sel4;
            g  = e.which ? grant1 : grant4;
            se = e.which ? se1    : se4;
            b  = e.which ? busy1  : busy4;
            n_checks++;
            if (s === exp_sel(e.grant) && g === e.grant && se === e.se && b === e.busy)
                n_pass++;
            else
                $display("FAIL %s @cyc%0d: got sel=%b grant=%b slot_end=%b busy=%b, want sel=%b grant=%b slot_end=%b busy=%b",
                         e.name, cyc, s, g, se, b, exp_sel(e.grant), e.grant, e.se, e.busy);
        end
    end

    task automatic step(input logic [2:0] r, input logic h, input logic rs, input bit which,
                        input logic [2:0] g, input logic se, input logic b, input string nm);
        exp_t x;
        req   = r;
        hold  = h;
        reset = rs;
        x.due = cyc + 1; x.which = which; x.grant = g; x.se = se; x.busy = b; x.name = nm;
        q.push_back(x);
        @(posedge clock);
        #1;
    endtask

    logic [2:0] rot [4];

    initial begin
        rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100; rot[3] = 3'b001;
        @(posedge clock);
        #1;

        // 1: reset, then idle
        step(3'b000, 0, 1, 0, 3'b000, 0, 0, "t1_reset");
        for (int i = 0; i < 10; i++) step(3'b000, 0, 0, 0, 3'b000, 0, 0, "t1_idle");

        // 2: all requesting, full rotation D0,D1,D2,D0
        step(3'b000, 0, 1, 0, 3'b000, 0, 0, "t2_reset");
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++)
                step(3'b111, 0, 0, 0, rot[k], (k > 0 && c == 0), 1, "t2_rotate");

        // 3: lone requester D1 keeps the digit, new slot every 4 cycles
        step(3'b000, 0, 1, 0, 3'b000, 0, 0, "t3_reset");
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++)
                step(3'b010, 0, 0, 0, 3'b010, (k > 0 && c == 0), 1, "t3_lone");

        // 4: owner abort hands over, then everything drops to idle
        step(3'b000, 0, 1, 0, 3'b000, 0, 0, "t4_reset");
        step(3'b011, 0, 0, 0, 3'b001, 0, 1, "t4_grant_d0");
        step(3'b011, 0, 0, 0, 3'b001, 0, 1, "t4_cnt1");
        step(3'b010, 0, 0, 0, 3'b010, 0, 1, "t4_abort_to_d1");
        step(3'b010, 0, 0, 0, 3'b010, 0, 1, "t4_d1_hold");
        step(3'b000, 0, 0, 0, 3'b000, 0, 0, "t4_abort_idle");
        step(3'b000, 0, 0, 0, 3'b000, 0, 0, "t4_idle");

        // 5: hold freezes the slot mid-dwell, then it completes and D2 follows
        step(3'b000, 0, 1, 0, 3'b000, 0, 0, "t5_reset");
        step(3'b101, 0, 0, 0, 3'b001, 0, 1, "t5_grant_d0");
        step(3'b101, 0, 0, 0, 3'b001, 0, 1, "t5_cnt1");
        for (int i = 0; i < 6; i++) step(3'b101, 1, 0, 0, 3'b001, 0, 1, "t5_hold");
        step(3'b101, 0, 0, 0, 3'b001, 0, 1, "t5_cnt2");
        step(3'b101, 0, 0, 0, 3'b001, 0, 1, "t5_cnt3");
        step(3'b101, 0, 0, 0, 3'b100, 1, 1, "t5_end_to_d2");
        step(3'b101, 0, 0, 0, 3'b100, 0, 1, "t5_d2");

        // 6: reset mid-slot, then restart from D0
        step(3'b000, 0, 1, 0, 3'b000, 0, 0, "t6_reset");
        step(3'b111, 0, 0, 0, 3'b001, 0, 1, "t6_grant_d0");
        step(3'b111, 0, 0, 0, 3'b001, 0, 1, "t6_cnt1");
        step(3'b111, 0, 1, 0, 3'b000, 0, 0, "t6_mid_reset");
        step(3'b111, 0, 0, 0, 3'b001, 0, 1, "t6_restart_d0");
        step(3'b111, 0, 0, 0, 3'b001, 0, 1, "t6_restart_cnt1");

        // 6b: DWELL=1 rotates every cycle; hold still freezes
        step(3'b111, 0, 1, 1, 3'b000, 0, 0, "t6b_reset");
        step(3'b111, 0, 0, 1, 3'b001, 0, 1, "t6b_d0");
        step(3'b111, 0, 0, 1, 3'b010, 1, 1, "t6b_d1");
        step(3'b111, 0, 0, 1, 3'b100, 1, 1, "t6b_d2");
        step(3'b111, 0, 0, 1, 3'b001, 1, 1, "t6b_d0_again");
        step(3'b111, 1, 0, 1, 3'b001, 0, 1, "t6b_hold");
        step(3'b111, 0, 0, 1, 3'b010, 1, 1, "t6b_d1_again");

        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
